// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int XLEN      = 32;
    localparam int REG_KEY_W = 5;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10,
        LSU_RSVD = 2'b11
    } lsu_size_e;

    typedef struct packed {
        logic                 full;
        logic [REG_KEY_W-1:0] rd;
        logic [XLEN-1:0]      value;
        logic                 bad;
    } wb_slot_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Shifts a raw memory word down by the byte offset and
//               sign/zero-extends it; flags misaligned or reserved loads.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import wb_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] value,
    output logic            bad
);

    logic [XLEN-1:0] w_shifted;
    logic            w_sign_b;
    logic            w_sign_h;

    always_comb begin
        w_shifted = data >> {offset, 3'b000};
        w_sign_b  = !is_unsigned && w_shifted[7];
        w_sign_h  = !is_unsigned && w_shifted[15];
        value     = w_shifted;
        bad       = 1'b0;
        case (lsu_size_e'(size))
            LSU_BYTE: value = {{24{w_sign_b}}, w_shifted[7:0]};
            LSU_HALF: begin
                value = {{16{w_sign_h}}, w_shifted[15:0]};
                bad   = (offset == 2'd3);
            end
            LSU_WORD: begin
                value = w_shifted;
                bad   = (offset != 2'd0);
            end
            default:  bad = 1'b1;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Buffers one ALU and one load result and drives the register
//               file's single write port, one write per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [REG_KEY_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_result,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [REG_KEY_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]      lsu_data,
    input  logic [1:0]           lsu_size,
    input  logic                 lsu_unsigned,
    input  logic [1:0]           lsu_byte_offset,
    output logic                 rf_portD_enable,
    output logic [REG_KEY_W-1:0] rf_portD_key,
    output logic [XLEN-1:0]      rf_portD_value,
    output logic                 lsu_misaligned,
    output logic                 busy
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);
    localparam logic [3:0] c_starve_max   = 4'hF;

    wb_slot_t               r_alu_slot;
    wb_slot_t               r_lsu_slot;
    logic [3:0]             r_starve;
    logic                   r_rf_en;
    logic [REG_KEY_W-1:0]   r_rf_key;
    logic [XLEN-1:0]        r_rf_value;
    logic                   r_misaligned;

    logic                   w_lsu_grant;
    logic                   w_alu_grant;
    logic                   w_alu_accept;
    logic                   w_lsu_accept;
    wb_slot_t               w_win;
    logic [XLEN-1:0]        w_load_value;
    logic                   w_load_bad;

    load_align u_load_align (
        .data        (lsu_data),
        .size        (lsu_size),
        .is_unsigned (lsu_unsigned),
        .offset      (lsu_byte_offset),
        .value       (w_load_value),
        .bad         (w_load_bad)
    );

    // Grants look only at registered state so ready never depends on valid.
    assign w_lsu_grant  = r_lsu_slot.full &&
                          (!r_alu_slot.full || (r_starve >= c_starve_limit));
    assign w_alu_grant  = r_alu_slot.full && !w_lsu_grant;
    assign alu_ready    = !reset && (!r_alu_slot.full || w_alu_grant);
    assign lsu_ready    = !reset && (!r_lsu_slot.full || w_lsu_grant);
    assign w_alu_accept = alu_valid && alu_ready;
    assign w_lsu_accept = lsu_valid && lsu_ready;
    assign w_win        = w_lsu_grant ? r_lsu_slot : r_alu_slot;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_slot   <= '0;
            r_lsu_slot   <= '0;
            r_starve     <= 4'd0;
            r_rf_en      <= 1'b0;
            r_rf_key     <= '0;
            r_rf_value   <= '0;
            r_misaligned <= 1'b0;
        end else begin
            if (w_alu_accept) begin
                r_alu_slot <= '{full: 1'b1, rd: alu_rd, value: alu_result, bad: 1'b0};
            end else if (w_alu_grant) begin
                r_alu_slot.full <= 1'b0;
            end

            if (w_lsu_accept) begin
                r_lsu_slot <= '{full: 1'b1, rd: lsu_rd, value: w_load_value, bad: w_load_bad};
            end else if (w_lsu_grant) begin
                r_lsu_slot.full <= 1'b0;
            end

            // A bad load still burns its grant; only the enable is held low.
            if (w_lsu_grant || w_alu_grant) begin
                r_rf_key   <= w_win.rd;
                r_rf_value <= w_win.value;
                r_rf_en    <= (w_win.rd != '0) && !w_win.bad;
            end else begin
                r_rf_en    <= 1'b0;
            end

            r_misaligned <= w_lsu_grant && r_lsu_slot.bad;

            if (w_lsu_grant || !r_lsu_slot.full) begin
                r_starve <= 4'd0;
            end else if (r_starve != c_starve_max) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end

    assign rf_portD_enable = r_rf_en;
    assign rf_portD_key    = r_rf_key;
    assign rf_portD_value  = r_rf_value;
    assign lsu_misaligned  = r_misaligned;
    assign busy            = r_alu_slot.full || r_lsu_slot.full;

endmodule : writeback_arbiter
`default_nettype wire

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-side producer for the register file's single write port (port D).
- Collects completed results from the ALU pipe and the load/store unit (LSU) through valid/ready handshakes, buffers one result per source, and drives exactly one register-file write per cycle.
- Aligns and sign/zero-extends load data; writes to x0 and misaligned loads are suppressed.
- Sits between execute/memory stages and the register file.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a held LSU result may lose arbitration before it is forced to win. Legal range is 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU slot can accept this cycle
- alu_rd  in  5  ALU destination register key
- alu_result  in  32  ALU result value
- lsu_valid  in  1  load result offered
- lsu_ready  out  1  LSU slot can accept this cycle
- lsu_rd  in  5  load destination register key
- lsu_data  in  32  raw aligned memory word
- lsu_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- lsu_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- lsu_byte_offset  in  2  byte address bits [1:0]
- rf_portD_enable  out  1  register-file write enable (registered)
- rf_portD_key  out  5  write destination (registered)
- rf_portD_value  out  32  write data (registered)
- lsu_misaligned  out  1  one-cycle pulse: a load was dropped as misaligned/reserved
- busy  out  1  either slot occupied

Behaviour:
- State: alu_slot {full, rd, value}; lsu_slot {full, rd, value, bad}; starve counter (4 bits); registered port D outputs; lsu_misaligned.
- Reset (synchronous, clk edge with reset=1):
  - Both slots are emptied and the counter is cleared.
  - rf_portD_enable=0, rf_portD_key=0, rf_portD_value=0, lsu_misaligned=0.
  - alu_ready=lsu_ready=0 while reset=1; any valid offered during reset is discarded.
  - Reset mid-operation loses held results; this is intended, because the pipeline is flushed with it.
- Grant logic is combinational from registered state only and does not depend on *_valid:
  - lsu_grant = lsu_full && (!alu_full || starve >= STARVE_LIMIT).
  - alu_grant = alu_full && !lsu_grant.
- Ready: alu_ready = !reset && (!alu_full || alu_grant); lsu_ready likewise. An accept and a drain may occur in the same cycle, so the slot stays full with the new data.
- Capture on valid&&ready: ALU stores rd/result. LSU stores rd, extended value, and bad.
- Load alignment:
  - shifted = lsu_data >> (8*offset).
  - byte: shifted[7:0] extended to 32 bits.
  - half: shifted[15:0] extended.
  - word: shifted.
  - bad = (half && offset==3) || (word && offset!=0) || size==11.
- Port D register update each edge:
  - If a grant occurs: key/value take the granted slot's rd/value, and enable = (rd != 0) && !(lsu_grant && bad).
  - If there is no grant: enable=0 and key/value hold their previous values.
- lsu_misaligned is 1 in the cycle after an LSU grant with bad=1, else 0.
- Starve counter:
  - Reset to 0 on lsu_grant or when the LSU slot is empty.
  - Increments (saturating at 15) when lsu_full && !lsu_grant.
- Latency: handshake at edge E → granted during cycle E..E+1 → port D asserted in cycle after edge E+1 → register file commits at edge E+2. Minimum 2 edges.
- Throughput: one write per cycle. With both sources saturated, the LSU wins once every STARVE_LIMIT+1 cycles.
- Writes to x0 still consume a grant slot and a cycle; enable stays low.
- busy = alu_full || lsu_full.

Decomposition:
- Shared package wb_pkg:
  - XLEN=32, REG_KEY_W=5.
  - Size encodings LSU_BYTE, LSU_HALF, LSU_WORD, LSU_RSVD.
  - Slot struct typedef {full, rd, value, bad}.
- One natural sub-module: load_align, purely combinational (data, size, unsigned, offset → value, bad). It is instantiated once at LSU capture.

Test Plan:
- ALU alone: alu_valid with rd=5, result=0xDEADBEEF accepted at edge E → rf_portD_enable=1, key=5, value=0xDEADBEEF in cycle after E+1; enable=0 the next cycle.
- Load extension: byte, offset 2, signed, data=0x0080_0000 → value 0xFFFFFF80. Same stimulus with unsigned → 0x00000080. Half, offset 2, data 0x8001_0000, signed → 0xFFFF8001.
- Misaligned: word, offset 1, rd=7 → enable stays 0 in the write cycle, lsu_misaligned=1 for exactly one cycle, busy drops afterward.
- x0 drop: alu_rd=0, result=0x1234 → grant consumed, rf_portD_enable=0, alu_ready stays 1 throughout.
- Starvation, with STARVE_LIMIT=4, alu_valid held high continuously and one load pending:
  - ALU writes for 4 cycles, then the LSU write appears on port D.
  - lsu_ready=1 in the cycle of the LSU grant.
  - The starve counter returns to 0.
- Reset mid-flight: both slots full, assert reset for one edge → busy=0, all outputs 0, readies 0 during reset, and no stale write appears after reset.
